// File: rtl/controle_venda_pkg.sv
// Shared types and constants for the vending sale controller.
// The TROCO state only exists when VENDA_TROCO_EN is defined.
package controle_venda_pkg;

    localparam int unsigned VAL_W  = 4;
    localparam int unsigned PROD_W = 2;
    localparam int unsigned TMR_W  = 16;

    localparam logic [VAL_W-1:0] VALOR_EX    = 4'b1111;
    localparam logic [VAL_W-1:0] PRECO_A_DEF = 4'd5;
    localparam logic [VAL_W-1:0] PRECO_B_DEF = 4'd6;
    localparam logic [VAL_W-1:0] PRECO_C_DEF = 4'd8;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CREDITO = 3'd1,
        LIBERA  = 3'd2,
`ifdef VENDA_TROCO_EN
        TROCO   = 3'd3,
`endif
        DEVOLVE = 3'd4,
        LIMPA   = 3'd5
    } estado_e;

    typedef enum logic [PROD_W-1:0] {
        PROD_NENHUM = 2'b00,
        PROD_A      = 2'b01,
        PROD_B      = 2'b10,
        PROD_C      = 2'b11
    } produto_e;

    // Registered output bundle of the controller.
    typedef struct packed {
        logic              libera;
        logic [PROD_W-1:0] produto;
        logic [VAL_W-1:0]  troco;
        logic              troco_valido;
        logic              devolucao;
        logic              saldo_insuf;
        logic              tempo_limite;
    } saidas_t;

    function automatic logic [VAL_W-1:0] preco_de(input logic [PROD_W-1:0] sel,
                                                  input logic [VAL_W-1:0]  pa,
                                                  input logic [VAL_W-1:0]  pb,
                                                  input logic [VAL_W-1:0]  pc);
        case (sel)
            PROD_A:  return pa;
            PROD_B:  return pb;
            PROD_C:  return pc;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/controle_venda_if.sv
// Accumulator/controller handshake: credit and requests in, pulses and amounts out.
interface controle_venda_if;
    import controle_venda_pkg::*;

    logic [VAL_W-1:0]  valorAcumulado;
    logic [PROD_W-1:0] selecao;
    logic              cancelar;
    logic              tempoLimite;
    logic              liberaProduto;
    logic [PROD_W-1:0] produto;
    logic [VAL_W-1:0]  troco;
    logic              trocoValido;
    logic              devolucao;
    logic              saldoInsuf;

    modport master (
        output valorAcumulado, selecao, cancelar,
        input  tempoLimite, liberaProduto, produto, troco, trocoValido, devolucao, saldoInsuf
    );

    modport slave (
        input  valorAcumulado, selecao, cancelar,
        output tempoLimite, liberaProduto, produto, troco, trocoValido, devolucao, saldoInsuf
    );

endinterface

// File: rtl/controle_venda_temporizador.sv
// Inactivity down-counter: carga reloads TOPO, decr counts down and holds at zero.
module temporizador_venda
    import controle_venda_pkg::*;
#(
    parameter int unsigned     W    = TMR_W,
    parameter logic [W-1:0]    TOPO = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic carga,
    input  logic decr,
    output logic zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (carga) begin
            cnt_q <= TOPO;
        end else if (decr && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/controle_venda.sv
// Vending sale controller: samples credit/selection, dispenses, returns change or refunds, clears credit.
// Change output (TROCO state) is built only when VENDA_TROCO_EN is defined.
module controle_venda
    import controle_venda_pkg::*;
#(
    parameter logic [VAL_W-1:0] PRECO_A        = PRECO_A_DEF,
    parameter logic [VAL_W-1:0] PRECO_B        = PRECO_B_DEF,
    parameter logic [VAL_W-1:0] PRECO_C        = PRECO_C_DEF,
    parameter logic [TMR_W-1:0] TIMEOUT_CICLOS = 16'd50000
) (
    input logic             clk,
    input logic             reset,
    controle_venda_if.slave vif
);

    localparam logic [TMR_W-1:0] TOPO = TIMEOUT_CICLOS - TMR_W'(1);

    estado_e           estado_q, estado_d;
    saidas_t           saidas_q, saidas_d;
    logic [PROD_W-1:0] insuf_sel_q, insuf_sel_d;
    logic [VAL_W-1:0]  val_ant_q;
    logic [VAL_W-1:0]  preco;
    logic              alterou;
    logic              carga;
    logic              decr;
    logic              zero;
`ifdef VENDA_TROCO_EN
    logic [VAL_W-1:0]  dif_q, dif_d;
`endif

    assign preco   = preco_de(vif.selecao, PRECO_A, PRECO_B, PRECO_C);
    assign alterou = (vif.valorAcumulado != val_ant_q);

    temporizador_venda #(
        .W    (TMR_W),
        .TOPO (TOPO)
    ) u_temporizador (
        .clk   (clk),
        .reset (reset),
        .carga (carga),
        .decr  (decr),
        .zero  (zero)
    );

    // Next state and next registered outputs; outputs are decoded from the state being entered.
    always_comb begin
        estado_d    = estado_q;
        saidas_d    = '0;
        insuf_sel_d = insuf_sel_q;
        carga       = 1'b0;
        decr        = 1'b0;
`ifdef VENDA_TROCO_EN
        dif_d       = dif_q;
`endif
        case (estado_q)
            OCIOSO: begin
                insuf_sel_d = '0;
                if (vif.valorAcumulado != '0) begin
                    estado_d = CREDITO;
                    carga    = 1'b1;
                end
            end
            CREDITO: begin
                // A coin landing on the expiry cycle counts as activity, not a timeout.
                if (vif.cancelar || (vif.valorAcumulado == VALOR_EX) || (zero && !alterou)) begin
                    estado_d           = DEVOLVE;
                    saidas_d.devolucao = 1'b1;
                    saidas_d.troco     = (vif.valorAcumulado == VALOR_EX) ? '0 : vif.valorAcumulado;
                end else if ((vif.selecao != '0) && (vif.valorAcumulado >= preco)) begin
                    estado_d         = LIBERA;
                    saidas_d.libera  = 1'b1;
                    saidas_d.produto = vif.selecao;
`ifdef VENDA_TROCO_EN
                    dif_d            = vif.valorAcumulado - preco;
`endif
                end else begin
                    // insuf_sel remembers the selection already flagged, so a held button pulses once.
                    if (vif.selecao == '0) begin
                        insuf_sel_d = '0;
                        decr        = !alterou;
                    end else if (vif.selecao != insuf_sel_q) begin
                        saidas_d.saldo_insuf = 1'b1;
                        insuf_sel_d          = vif.selecao;
                    end
                    carga = alterou;
                end
            end
            LIBERA: begin
`ifdef VENDA_TROCO_EN
                if (dif_q != '0) begin
                    estado_d              = TROCO;
                    saidas_d.troco_valido = 1'b1;
                    saidas_d.troco        = dif_q;
                end else begin
                    estado_d              = LIMPA;
                    saidas_d.tempo_limite = 1'b1;
                end
`else
                estado_d              = LIMPA;
                saidas_d.tempo_limite = 1'b1;
`endif
            end
`ifdef VENDA_TROCO_EN
            TROCO: begin
                estado_d              = LIMPA;
                saidas_d.tempo_limite = 1'b1;
            end
`endif
            DEVOLVE: begin
                estado_d              = LIMPA;
                saidas_d.tempo_limite = 1'b1;
            end
            LIMPA: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d              = LIMPA;
                saidas_d.tempo_limite = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            saidas_q    <= '0;
            insuf_sel_q <= '0;
            val_ant_q   <= '0;
`ifdef VENDA_TROCO_EN
            dif_q       <= '0;
`endif
        end else begin
            estado_q    <= estado_d;
            saidas_q    <= saidas_d;
            insuf_sel_q <= insuf_sel_d;
            val_ant_q   <= vif.valorAcumulado;
`ifdef VENDA_TROCO_EN
            dif_q       <= dif_d;
`endif
        end
    end

    assign vif.liberaProduto = saidas_q.libera;
    assign vif.produto       = saidas_q.produto;
    assign vif.troco         = saidas_q.troco;
    assign vif.trocoValido   = saidas_q.troco_valido;
    assign vif.devolucao     = saidas_q.devolucao;
    assign vif.saldoInsuf    = saidas_q.saldo_insuf;
    assign vif.tempoLimite   = saidas_q.tempo_limite;

endmodule
